seq_chunk_adder: RTL and testbench

- Multi-cycle, parametrised add/subtract unit; successor to the fixed 12-bit ripple adder.
- Processes operands CHUNK bits per clock, carrying between chunks in a register, so wide adds fit timing with a small adder.
- Uses a start/busy/done handshake and adds subtract mode and a signed-overflow flag.
- Used by datapath controllers that can tolerate multi-cycle arithmetic.

---
 rtl/seq_chunk_adder.sv | 121 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock with a registered carry
// between chunks, behind a start/busy/done handshake. WIDTH must be a multiple of CHUNK.
module seq_chunk_adder #(
    parameter int WIDTH = 12,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   a_chunk, b_chunk, s_chunk;
    logic               c_chunk;
    logic               last_chunk;

    assign a_chunk    = opa_q[cnt_q*CHUNK +: CHUNK];
    assign b_chunk    = opb_q[cnt_q*CHUNK +: CHUNK];
    assign {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    assign last_chunk = (cnt_q == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: operand, carry and working registers are always loaded on accept before use,
    // so they carry no reset and stay plain enable flops.
    always_ff @(posedge clk) begin
        opa_q   <= opa_d;
        opb_q   <= opb_d;
        carry_q <= carry_d;
        work_q  <= work_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && start) begin
            opa_d   = A;
            opb_d   = Sub ? ~B : B;
            carry_d = Cin ^ Sub;
            work_d  = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            // NOTE: blocking assignments here let the final chunk reach sum_d in the same cycle.
            work_d[cnt_q*CHUNK +: CHUNK] = s_chunk;
            carry_d = c_chunk;
            cnt_d   = last_chunk ? '0 : cnt_q + CNT_W'(1);
            if (last_chunk) begin
                sum_d  = work_d;
                cout_d = c_chunk;
                ovf_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (s_chunk[CHUNK-1] != opa_q[WIDTH-1]);
            end
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three builds (12/4, 12/12, 16/1) checked cycle by cycle
// against an arithmetic reference model.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v [3];
    logic [15:0] a_v [3];
    logic [15:0] b_v [3];
    logic        cin_v [3];
    logic        sub_v [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic        cout_v [3];
    logic        ovf_v [3];
    logic [11:0] sum0, sum1;
    logic [15:0] sum2;
    logic [15:0] sum_v [3];

    logic [15:0] prev_sum [3];
    logic        prev_cout [3];
    logic        prev_ovf [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(12), .CHUNK(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0][11:0]), .B(b_v[0][11:0]),
        .Cin(cin_v[0]), .Sub(sub_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .Sum(sum0), .Cout(cout_v[0]), .Ovf(ovf_v[0])
    );

    seq_chunk_adder #(.WIDTH(12), .CHUNK(12)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1][11:0]), .B(b_v[1][11:0]),
        .Cin(cin_v[1]), .Sub(sub_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .Sum(sum1), .Cout(cout_v[1]), .Ovf(ovf_v[1])
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]),
        .Cin(cin_v[2]), .Sub(sub_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .Sum(sum2), .Cout(cout_v[2]), .Ovf(ovf_v[2])
    );

    always_comb begin
        sum_v[0] = {4'h0, sum0};
        sum_v[1] = {4'h0, sum1};
        sum_v[2] = sum2;
    end

    function automatic int w_of(input int idx);
        return (idx == 2) ? 16 : 12;
    endfunction

    function automatic int n_of(input int idx);
        case (idx)
            0:       return 3;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A+B+Cin or A-B-Cin on the integer line, then reduced modulo 2^w.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub,
                                  output logic [15:0] s, output logic co, output logic ov);
        longint m  = longint'(1) << w;
        longint h  = m / 2;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint ci = cin ? 1 : 0;
        longint sa = (ua >= h) ? ua - m : ua;
        longint sb = (ub >= h) ? ub - m : ub;
        longint t, st;
        if (!sub) begin
            t  = ua + ub + ci;
            co = (t >= m);
            st = sa + sb + ci;
        end else begin
            t  = ua - ub - ci;
            co = (t >= 0);
            st = sa - sb - ci;
        end
        s  = 16'(((t % m) + m) % m);
        ov = (st >= h) || (st < -h);
    endfunction

    task automatic clear_prev();
        for (int i = 0; i < 3; i++) begin
            prev_sum[i]  = '0;
            prev_cout[i] = 1'b0;
            prev_ovf[i]  = 1'b0;
        end
    endtask

    // Called at a negedge: presents one request, then checks every cycle up to the next
    // accept opportunity. poke re-asserts start mid-run; do_rst aborts with a reset.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input bit hold, input bit poke, input bit do_rst);
        int          n = n_of(idx);
        int          w = w_of(idx);
        logic [15:0] es;
        logic        ec, eo;
        model(w, a, b, cin, sub, es, ec, eo);
        start_v[idx] = 1'b1;
        a_v[idx] = a;
        b_v[idx] = b;
        cin_v[idx] = cin;
        sub_v[idx] = sub;
        for (int j = 1; j <= n + 2; j++) begin
            @(negedge clk);
            check($sformatf("u%0d.busy@%0d", idx, j), 32'(busy_v[idx]), 32'(j <= n + 1));
            check($sformatf("u%0d.done@%0d", idx, j), 32'(done_v[idx]), 32'(j == n + 1));
            if (j <= n) begin
                check($sformatf("u%0d.hold_sum@%0d", idx, j), 32'(sum_v[idx]), 32'(prev_sum[idx]));
                check($sformatf("u%0d.hold_cout@%0d", idx, j), 32'(cout_v[idx]), 32'(prev_cout[idx]));
            end
            if (j == n + 1) begin
                check($sformatf("u%0d.sum a=%0h b=%0h c=%0b s=%0b", idx, a, b, cin, sub),
                      32'(sum_v[idx]), 32'(es));
                check($sformatf("u%0d.cout a=%0h b=%0h c=%0b s=%0b", idx, a, b, cin, sub),
                      32'(cout_v[idx]), 32'(ec));
                check($sformatf("u%0d.ovf a=%0h b=%0h c=%0b s=%0b", idx, a, b, cin, sub),
                      32'(ovf_v[idx]), 32'(eo));
                prev_sum[idx]  = es;
                prev_cout[idx] = ec;
                prev_ovf[idx]  = eo;
            end
            if (j == 1) begin
                start_v[idx] = hold;
                a_v[idx] = 16'($urandom);
                b_v[idx] = 16'($urandom);
                cin_v[idx] = 1'($urandom);
                sub_v[idx] = 1'($urandom);
            end
            if (poke && j == 2) begin
                start_v[idx] = 1'b1;
                a_v[idx] = 16'hFFF;
                b_v[idx] = 16'hFFF;
            end
            if (poke && j == 3) start_v[idx] = hold;
            if (do_rst && j == 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                clear_prev();
                for (int k = 0; k < n + 2; k++) begin
                    check($sformatf("u%0d.rst_busy@%0d", idx, k), 32'(busy_v[idx]), 32'd0);
                    check($sformatf("u%0d.rst_done@%0d", idx, k), 32'(done_v[idx]), 32'd0);
                    check($sformatf("u%0d.rst_sum@%0d", idx, k), 32'(sum_v[idx]), 32'd0);
                    check($sformatf("u%0d.rst_flags@%0d", idx, k),
                          32'({cout_v[idx], ovf_v[idx]}), 32'd0);
                    @(negedge clk);
                end
                return;
            end
        end
    endtask

    task automatic random_batch(input int idx, input int count);
        logic [15:0] mask = 16'((32'd1 << w_of(idx)) - 1);
        for (int i = 0; i < count; i++) begin
            run_op(idx, 16'($urandom) & mask, 16'($urandom) & mask,
                   1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
        end
        start_v[idx] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            a_v[i] = '0;
            b_v[i] = '0;
            cin_v[i] = 1'b0;
            sub_v[i] = 1'b0;
        end
        clear_prev();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.reset_busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("u%0d.reset_done", i), 32'(done_v[i]), 32'd0);
            check($sformatf("u%0d.reset_sum", i), 32'(sum_v[i]), 32'd0);
            check($sformatf("u%0d.reset_cout", i), 32'(cout_v[i]), 32'd0);
            check($sformatf("u%0d.reset_ovf", i), 32'(ovf_v[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 16'h7FF, 16'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'hFFF, 16'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h005, 16'h007, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h800, 16'h001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h123, 16'h111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(0, 16'h3C3, 16'h0F0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(0, 16'h0AA, 16'h055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1, 16'hFFF, 16'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        random_batch(0, 200);
        random_batch(1, 500);
        random_batch(2, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
